// File: rtl/jtag_ir_dr_chain.sv
// rtl/jtag_ir_dr_chain.sv - JTAG IR/DR chain with BYPASS, USER and optional IDCODE (JTAG_IDCODE_EN) registers
module jtag_ir_dr_chain #(
    parameter int                  IR_WIDTH   = 4,
    parameter int                  DR_WIDTH   = 32,
    parameter logic [IR_WIDTH-1:0] USER_OPC   = 4'b0010,
    parameter logic [IR_WIDTH-1:0] IDCODE_OPC = 4'b0001,
    parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                tdi,
    input  logic                test_logic_reset,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic [DR_WIDTH-1:0] dr_in,
    output logic                tdo,
    output logic                tdo_en,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [DR_WIDTH-1:0] dr_out,
    output logic                dr_update,
    output logic                user_sel
);

    localparam logic [IR_WIDTH-1:0] BYPASS_OPC = '1;
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] DEFAULT_INSTR = IDCODE_OPC;
`else
    localparam logic [IR_WIDTH-1:0] DEFAULT_INSTR = BYPASS_OPC;
    localparam logic [IR_WIDTH+31:0] unused_idcode_cfg = {IDCODE_OPC, IDCODE_VAL};
`endif

    logic [IR_WIDTH-1:0] ir_sr;
    logic [DR_WIDTH-1:0] user_sr;
    logic                bypass_q;
    logic                bypass_sel;
    logic                sel_bit;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_sr  <= '0;
            ir_out <= DEFAULT_INSTR;
        end else begin
            if (capture_ir)
                ir_sr <= IR_WIDTH'(1);
            else if (shift_ir)
                ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            if (test_logic_reset)
                ir_out <= DEFAULT_INSTR;
            else if (update_ir)
                ir_out <= ir_sr;
        end
    end

    assign user_sel = (ir_out == USER_OPC);

`ifdef JTAG_IDCODE_EN
    logic        idcode_sel;
    logic [31:0] idcode_sr;

    assign idcode_sel = (ir_out == IDCODE_OPC) && !user_sel;
    assign bypass_sel = !user_sel && !idcode_sel;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n)
            idcode_sr <= '0;
        else if (idcode_sel) begin
            if (capture_dr)
                idcode_sr <= IDCODE_VAL;
            else if (shift_dr)
                idcode_sr <= {tdi, idcode_sr[31:1]};
        end
    end
`else
    // Undefined opcodes, IDCODE_OPC included, fall through to BYPASS.
    assign bypass_sel = !user_sel;
`endif

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            user_sr  <= '0;
            bypass_q <= 1'b0;
        end else begin
            if (user_sel) begin
                if (capture_dr)
                    user_sr <= dr_in;
                else if (shift_dr)
                    user_sr <= {tdi, user_sr[DR_WIDTH-1:1]};
            end
            if (bypass_sel) begin
                if (capture_dr)
                    bypass_q <= 1'b0;
                else if (shift_dr)
                    bypass_q <= tdi;
            end
        end
    end

    // update_dr lasts one tck, so the registered strobe is exactly one cycle wide.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            dr_out    <= '0;
            dr_update <= 1'b0;
        end else begin
            dr_update <= update_dr && user_sel && !test_logic_reset;
            if (update_dr && user_sel)
                dr_out <= user_sr;
        end
    end

    always_comb begin
        sel_bit = bypass_q;
        if (user_sel)
            sel_bit = user_sr[0];
`ifdef JTAG_IDCODE_EN
        else if (idcode_sel)
            sel_bit = idcode_sr[0];
`endif
        tdo = 1'b0;
        if (shift_ir)
            tdo = ir_sr[0];
        else if (shift_dr)
            tdo = sel_bit;
    end

    assign tdo_en = shift_ir | shift_dr;

endmodule
